// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and
// feeds the IF/ID register, honouring downstream stall and branch redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        hazardDetected_i,
    input  logic        branchTaken_i,
    input  logic [31:0] branchTarget_i,
    output logic [31:0] instr_o,
    output logic [31:0] instrAddr_o,
    output logic        instrValid_o,
    output logic        IFFlush_o
);

    // Handshake: a fetch is requested while imem_req_o=1 and completes in the
    // cycle imem_ack_i=1 (possibly the first one); imem_addr_o holds until then.
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] drain_addr_q;
    logic [31:0] instr_q;
    logic [31:0] instr_addr_q;
    logic        valid_q;
    logic [31:0] hold_data_q;
    logic [31:0] hold_addr_q;
    logic        slot_free;

    assign pc_d      = pc_q + PC_STEP;
    assign slot_free = !valid_q || !hazardDetected_i;

    assign imem_req_o   = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr_o  = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign instr_o      = instr_q;
    assign instrAddr_o  = instr_addr_q;
    assign instrValid_o = valid_q;
    assign IFFlush_o    = branchTaken_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            instr_q      <= 32'h0;
            instr_addr_q <= 32'h0;
            valid_q      <= 1'b0;
            hold_data_q  <= 32'h0;
            hold_addr_q  <= 32'h0;
        end else if (branchTaken_i) begin
            instr_q      <= 32'h0;
            instr_addr_q <= 32'h0;
            valid_q      <= 1'b0;
            hold_data_q  <= 32'h0;
            hold_addr_q  <= 32'h0;
            pc_q         <= branchTarget_i;
            case (state_q)
                FETCH: begin
                    // An unacked request must still complete at its old address.
                    if (imem_ack_i) begin
                        state_q <= FETCH;
                    end else begin
                        state_q      <= DRAIN;
                        drain_addr_q <= pc_q;
                    end
                end
                DRAIN:   state_q <= imem_ack_i ? FETCH : DRAIN;
                default: state_q <= FETCH;
            endcase
        end else begin
            if (!hazardDetected_i) begin
                instr_q      <= 32'h0;
                instr_addr_q <= 32'h0;
                valid_q      <= 1'b0;
            end
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (imem_ack_i) begin
                        pc_q <= pc_d;
                        if (slot_free) begin
                            instr_q      <= imem_data_i;
                            instr_addr_q <= pc_q;
                            valid_q      <= 1'b1;
                        end else begin
                            hold_data_q <= imem_data_i;
                            hold_addr_q <= pc_q;
                            state_q     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!hazardDetected_i) begin
                        instr_q      <= hold_data_q;
                        instr_addr_q <= hold_addr_q;
                        valid_q      <= 1'b1;
                        state_q      <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack_i) state_q <= FETCH;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
